// File: rtl/data_memory_controller.sv
// Multi-cycle data memory for the MA stage: byte/half/word loads and stores
// with a fixed LATENCY-cycle access phase, stalling the pipeline via busy.
module data_memory_controller #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  func_3,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        busy,
    output logic        misaligned
);

    localparam int unsigned AW       = $clog2(MEM_DEPTH);
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [3:0]      cnt;
    logic [3:0]      cnt_next;
    logic            request;
    logic            accept;
    logic            commit;

    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [2:0]      f3_q;
    logic            store_q;

    logic [31:0]     mem [MEM_DEPTH];
    logic [AW-1:0]   idx;
    logic [31:0]     word;
    logic [31:0]     shifted;
    logic [7:0]      sel_byte;
    logic [15:0]     sel_half;
    logic [31:0]     load_val;
    logic [31:0]     store_val;
    logic [3:0]      lane_we;
    logic            supported;
    logic            is_mis;
    logic            access_ok;
    logic            unused_addr_bits;

    // Address bits above the array size wrap around and are deliberately ignored.
    assign unused_addr_bits = ^address[31:AW+2];

    assign request = mem_read | mem_write;

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        busy       = 1'b0;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (request) begin
                    busy       = 1'b1;
                    accept     = 1'b1;
                    cnt_next   = CNT_LOAD;
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                busy = 1'b1;
                if (cnt == 4'd0) begin
                    commit     = 1'b1;
                    next_state = DONE;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign idx      = addr_q[AW+1:2];
    assign word     = mem[idx];
    assign shifted  = word >> {addr_q[1:0], 3'b000};
    assign sel_byte = shifted[7:0];
    assign sel_half = addr_q[1] ? word[31:16] : word[15:0];

    always_comb begin
        supported = 1'b0;
        is_mis    = 1'b0;
        load_val  = '0;
        store_val = '0;
        lane_we   = '0;
        case (f3_q)
            3'b000: begin
                supported = 1'b1;
                load_val  = {{24{sel_byte[7]}}, sel_byte};
                store_val = {4{wdata_q[7:0]}};
                lane_we   = 4'b0001 << addr_q[1:0];
            end
            3'b001: begin
                supported = 1'b1;
                is_mis    = addr_q[0];
                load_val  = {{16{sel_half[15]}}, sel_half};
                store_val = {2{wdata_q[15:0]}};
                lane_we   = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            3'b010: begin
                supported = 1'b1;
                is_mis    = (addr_q[1:0] != 2'b00);
                load_val  = word;
                store_val = wdata_q;
                lane_we   = 4'b1111;
            end
            3'b100: begin
                supported = ~store_q;
                load_val  = {24'd0, sel_byte};
            end
            3'b101: begin
                supported = ~store_q;
                is_mis    = addr_q[0];
                load_val  = {16'd0, sel_half};
            end
            default: begin
                supported = 1'b0;
            end
        endcase
    end

    assign access_ok = supported & ~is_mis;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state      <= IDLE;
            cnt        <= '0;
            read_data  <= '0;
            misaligned <= 1'b0;
        end else begin
            state      <= next_state;
            cnt        <= cnt_next;
            misaligned <= commit & supported & is_mis;
            if (commit && !store_q) begin
                read_data <= access_ok ? load_val : '0;
            end
            if (accept) begin
                addr_q  <= address[AW+1:0];
                wdata_q <= write_data;
                f3_q    <= func_3;
                store_q <= mem_write;
            end
        end
    end

    // Array has no reset; gating with RESET drops a store whose commit edge meets reset.
    always_ff @(posedge CLK) begin
        if (RESET && commit && store_q && access_ok) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (lane_we[i]) begin
                    mem[idx][i*8 +: 8] <= store_val[i*8 +: 8];
                end
            end
        end
    end

endmodule
